// File: rtl/mem_read_sequencer.sv
// SPI command sequencer for an array of dual-bank memories: streaming READ
// with auto-increment and wrap, ID and STATUS responses, out-of-range counting.
module mem_read_sequencer #(
    parameter int N_CHIPS     = 20,
    parameter int BYTE_ADDR_W = 8,
    parameter int ADDR_W      = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_cs,
    input  logic                   i_rx_valid,
    input  logic [7:0]             i_rx_byte,
    input  logic                   i_tx_ready,
    output logic                   o_tx_valid,
    output logic [7:0]             o_tx_byte,
    output logic [N_CHIPS-1:0]     o_mem_cs,
    output logic [BYTE_ADDR_W-1:0] o_mem_addr,
    output logic                   o_mem_bank,
    input  logic [7:0]             i_mem_data,
    output logic                   o_busy,
    output logic [2:0]             o_state
);

    localparam int              CHIP_W  = ADDR_W - BYTE_ADDR_W - 1;
    localparam longint          TOTAL_L = longint'(N_CHIPS) << (BYTE_ADDR_W + 1);
    // One extra bit so TOTAL fits even when it equals 2^ADDR_W.
    localparam logic [ADDR_W:0] TOTAL   = TOTAL_L[ADDR_W:0];
    localparam logic [ADDR_W:0] LAST    = TOTAL - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CMD     = 3'd1,
        S_ADDR_HI = 3'd2,
        S_ADDR_LO = 3'd3,
        S_FETCH   = 3'd4,
        S_CAPTURE = 3'd5,
        S_SEND    = 3'd6,
        S_DRAIN   = 3'd7
    } state_t;

    typedef enum logic [1:0] {
        K_READ   = 2'd0,
        K_ID     = 2'd1,
        K_STATUS = 2'd2
    } kind_t;

    state_t               r_state;
    kind_t                r_kind;
    logic [ADDR_W-1:0]    r_addr;
    logic [7:0]           r_addr_hi;
    logic [1:0]           r_resp_idx;
    logic [7:0]           r_err_cnt;
    logic                 r_in_range;
    logic                 r_tx_valid;
    logic [7:0]           r_tx_byte;
    logic [N_CHIPS-1:0]   r_mem_cs;
    logic [BYTE_ADDR_W-1:0] r_mem_addr;
    logic                 r_mem_bank;

    logic [15:0]          w_rx_addr16;
    logic [ADDR_W-1:0]    w_inc_addr;
    logic [ADDR_W-1:0]    w_fetch_addr;
    logic                 w_in_range;
    logic [CHIP_W-1:0]    w_chip;
    logic [N_CHIPS-1:0]   w_cs;
    logic                 w_accept;
    logic                 w_start_fetch;
    logic [1:0]           w_resp_idx_nxt;

    function automatic logic [7:0] resp_byte(input kind_t k, input logic [1:0] idx,
                                             input logic [7:0] err);
        logic [7:0] b;
        b = 8'h00;
        if (k == K_ID) begin
            case (idx)
                2'd0:    b = 8'hA5;
                2'd1:    b = 8'(N_CHIPS);
                2'd2:    b = 8'(BYTE_ADDR_W);
                default: b = 8'h00;
            endcase
        end else if (k == K_STATUS && idx == 2'd0) begin
            b = err;
        end
        return b;
    endfunction

    assign w_rx_addr16    = {r_addr_hi, i_rx_byte};
    assign w_inc_addr     = ({1'b0, r_addr} >= LAST) ? '0 : r_addr + 1'b1;
    assign w_fetch_addr   = (r_state == S_ADDR_LO) ? w_rx_addr16[ADDR_W-1:0] : w_inc_addr;
    assign w_in_range     = ({1'b0, w_fetch_addr} < TOTAL);
    assign w_chip         = w_fetch_addr[ADDR_W-1:BYTE_ADDR_W+1];
    assign w_accept       = (r_state == S_SEND) && r_tx_valid && i_tx_ready;
    assign w_start_fetch  = ((r_state == S_ADDR_LO) && i_rx_valid) ||
                            (w_accept && r_kind == K_READ);
    assign w_resp_idx_nxt = (r_resp_idx == 2'd3) ? 2'd3 : r_resp_idx + 2'd1;

    // NOTE: w_cs gets a full default before the loop so no latch is inferred.
    always_comb begin
        w_cs = '0;
        for (int i = 0; i < N_CHIPS; i++) begin
            if (w_in_range && w_chip == CHIP_W'(i)) w_cs[i] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= S_IDLE;
            r_kind     <= K_READ;
            r_addr     <= '0;
            r_addr_hi  <= '0;
            r_resp_idx <= '0;
            r_err_cnt  <= '0;
            r_in_range <= 1'b0;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= '0;
            r_mem_cs   <= '0;
            r_mem_addr <= '0;
            r_mem_bank <= 1'b0;
        end else if (i_cs) begin
            // Deselect aborts everything, including a same-cycle acceptance.
            r_state    <= S_IDLE;
            r_addr     <= '0;
            r_addr_hi  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_byte  <= '0;
            r_mem_cs   <= '0;
            r_mem_addr <= '0;
            r_mem_bank <= 1'b0;
        end else begin
            r_mem_cs <= '0;
            if (w_start_fetch) begin
                r_state    <= S_FETCH;
                r_addr     <= w_fetch_addr;
                r_in_range <= w_in_range;
                r_tx_valid <= 1'b0;
                r_mem_cs   <= w_cs;
                r_mem_addr <= w_fetch_addr[BYTE_ADDR_W-1:0];
                r_mem_bank <= w_fetch_addr[BYTE_ADDR_W];
                if (!w_in_range && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            end else begin
                case (r_state)
                    S_IDLE: r_state <= S_CMD;
                    S_CMD: begin
                        if (i_rx_valid) begin
                            r_resp_idx <= '0;
                            case (i_rx_byte)
                                8'h03: begin
                                    r_kind  <= K_READ;
                                    r_state <= S_ADDR_HI;
                                end
                                8'h9F: begin
                                    r_kind     <= K_ID;
                                    r_tx_byte  <= resp_byte(K_ID, 2'd0, r_err_cnt);
                                    r_tx_valid <= 1'b1;
                                    r_state    <= S_SEND;
                                end
                                8'h05: begin
                                    r_kind     <= K_STATUS;
                                    r_tx_byte  <= resp_byte(K_STATUS, 2'd0, r_err_cnt);
                                    r_tx_valid <= 1'b1;
                                    r_state    <= S_SEND;
                                end
                                default: r_state <= S_DRAIN;
                            endcase
                        end
                    end
                    S_ADDR_HI: begin
                        if (i_rx_valid) begin
                            r_addr_hi <= i_rx_byte;
                            r_state   <= S_ADDR_LO;
                        end
                    end
                    S_FETCH:   r_state <= S_CAPTURE;
                    S_CAPTURE: begin
                        r_tx_byte  <= r_in_range ? i_mem_data : 8'hFF;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_accept) begin
                            r_resp_idx <= w_resp_idx_nxt;
                            r_tx_byte  <= resp_byte(r_kind, w_resp_idx_nxt, r_err_cnt);
                        end
                    end
                    S_DRAIN:   r_state <= S_DRAIN;
                    default:   r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign o_tx_valid = r_tx_valid;
    assign o_tx_byte  = r_tx_byte;
    assign o_mem_cs   = r_mem_cs;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_bank = r_mem_bank;
    assign o_busy     = (r_state != S_IDLE);
    assign o_state    = r_state;

endmodule

// File: tb/tb_mem_read_sequencer.sv
// Scoreboard bench for mem_read_sequencer: a behavioural memory array answers
// fetches; expected tx bytes and fetches are queued at stimulus time.
module tb_mem_read_sequencer;

    localparam int N     = 20;
    localparam int BW    = 8;
    localparam int AW    = 16;
    localparam int TOTAL = N * 512;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b0;
    logic          i_cs = 1'b1;
    logic          i_rx_valid = 1'b0;
    logic [7:0]    i_rx_byte = 8'h00;
    logic          i_tx_ready = 1'b0;
    logic          o_tx_valid;
    logic [7:0]    o_tx_byte;
    logic [N-1:0]  o_mem_cs;
    logic [BW-1:0] o_mem_addr;
    logic          o_mem_bank;
    logic [7:0]    mem_rd = 8'h00;
    logic          o_busy;
    logic [2:0]    o_state;

    typedef struct {
        logic         in_range;
        logic [N-1:0] cs;
        logic [7:0]   addr;
        logic         bank;
    } fetch_t;

    logic [7:0] exp_q[$];
    fetch_t     fetch_q[$];
    int         n_cmp = 0;
    int         n_mis = 0;

    mem_read_sequencer #(.N_CHIPS(N), .BYTE_ADDR_W(BW), .ADDR_W(AW)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_cs(i_cs),
        .i_rx_valid(i_rx_valid), .i_rx_byte(i_rx_byte), .i_tx_ready(i_tx_ready),
        .o_tx_valid(o_tx_valid), .o_tx_byte(o_tx_byte),
        .o_mem_cs(o_mem_cs), .o_mem_addr(o_mem_addr), .o_mem_bank(o_mem_bank),
        .i_mem_data(mem_rd), .o_busy(o_busy), .o_state(o_state)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] mem_model(input logic [15:0] a);
        return a[7:0] + 8'h55 + 8'(a[15:8] * 3);
    endfunction

    // Synchronous-read memory array: data appears the cycle after its chip select.
    always @(posedge i_clk) begin
        mem_rd <= 8'hEE;
        for (int c = 0; c < N; c++)
            if (o_mem_cs[c]) mem_rd <= mem_model({7'(c), o_mem_bank, o_mem_addr});
    end

    task automatic tick();
        @(negedge i_clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        i_rx_valid = 1'b1;
        i_rx_byte  = b;
        tick();
        i_rx_valid = 1'b0;
    endtask

    task automatic open_cs(input string tag);
        i_cs = 1'b0;
        tick();
        n_cmp++;
        if (o_state !== 3'd1) begin
            n_mis++;
            $display("FAIL %s open: state=%0d want 1", tag, o_state);
        end
    endtask

    task automatic close_cs(input string tag);
        i_cs = 1'b1;
        tick();
        n_cmp++;
        if (o_state !== 3'd0 || o_tx_valid !== 1'b0 || o_mem_cs !== '0 || o_busy !== 1'b0) begin
            n_mis++;
            $display("FAIL %s close: state=%0d valid=%b cs=%h busy=%b want 0/0/0/0",
                     tag, o_state, o_tx_valid, o_mem_cs, o_busy);
        end
    endtask

    task automatic push_read(input int start, input int n);
        int a;
        fetch_t f;
        logic [N-1:0] one;
        one = 1;
        a = start;
        for (int k = 0; k < n; k++) begin
            f.in_range = (a < TOTAL);
            f.cs       = f.in_range ? (one << (a >> 9)) : '0;
            f.addr     = 8'(a & 255);
            f.bank     = 1'((a >> 8) & 1);
            fetch_q.push_back(f);
            exp_q.push_back(f.in_range ? mem_model(16'(a)) : 8'hFF);
            a = (a >= TOTAL - 1) ? 0 : a + 1;
        end
    endtask

    // Pops one expected byte per DUT output; also checks fetches seen on the way.
    task automatic recv(input int n, input int exp_gap, input string tag);
        fetch_t f;
        logic [7:0] e;
        int gap;
        for (int k = 0; k < n; k++) begin
            gap = 0;
            while (o_tx_valid !== 1'b1 && gap < 20) begin
                if (o_state === 3'd4) begin
                    n_cmp++;
                    if (fetch_q.size() == 0) begin
                        n_mis++;
                        $display("FAIL %s fetch: unexpected fetch cs=%h", tag, o_mem_cs);
                    end else begin
                        f = fetch_q.pop_front();
                        if (o_mem_cs !== f.cs ||
                            (f.in_range && (o_mem_addr !== f.addr || o_mem_bank !== f.bank))) begin
                            n_mis++;
                            $display("FAIL %s fetch: cs=%h addr=%h bank=%b want cs=%h addr=%h bank=%b",
                                     tag, o_mem_cs, o_mem_addr, o_mem_bank, f.cs, f.addr, f.bank);
                        end
                    end
                end
                tick();
                gap++;
            end
            n_cmp++;
            if (gap >= 20) begin
                n_mis++;
                $display("FAIL %s timeout: no tx_valid for byte %0d", tag, k);
                return;
            end
            n_cmp++;
            if (gap != exp_gap) begin
                n_mis++;
                $display("FAIL %s gap: %0d idle cycles want %0d", tag, gap, exp_gap);
            end
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hXX;
            n_cmp++;
            if (o_tx_byte !== e) begin
                n_mis++;
                $display("FAIL %s byte%0d: got %h want %h", tag, k, o_tx_byte, e);
            end
            i_tx_ready = 1'b1;
            tick();
            i_tx_ready = 1'b0;
        end
    endtask

    task automatic do_read(input int start, input int n, input string tag);
        exp_q.delete();
        fetch_q.delete();
        open_cs(tag);
        send_byte(8'h03);
        send_byte(8'(start >> 8));
        send_byte(8'(start & 255));
        push_read(start, n);
        recv(n, 2, tag);
        close_cs(tag);
    endtask

    task automatic test_status(input logic [7:0] err, input string tag);
        exp_q.delete();
        open_cs(tag);
        send_byte(8'h05);
        exp_q.push_back(err);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h00);
        recv(3, 0, tag);
        close_cs(tag);
    endtask

    task automatic test_reset();
        int gap;
        i_rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({o_tx_valid, o_tx_byte, o_mem_cs, o_mem_addr, o_mem_bank, o_busy, o_state} !== '0) begin
            n_mis++;
            $display("FAIL reset_init: valid=%b byte=%h cs=%h addr=%h bank=%b busy=%b state=%0d want all 0",
                     o_tx_valid, o_tx_byte, o_mem_cs, o_mem_addr, o_mem_bank, o_busy, o_state);
        end
        i_rst = 1'b1;
        tick();
        // Out-of-range read bumps the error counter, then reset lands during SEND.
        open_cs("reset_mid");
        send_byte(8'h03);
        send_byte(8'h28);
        send_byte(8'h00);
        gap = 0;
        while (o_tx_valid !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        n_cmp++;
        if (o_state !== 3'd6) begin
            n_mis++;
            $display("FAIL reset_mid send: state=%0d want 6", o_state);
        end
        i_rst      = 1'b0;
        i_tx_ready = 1'b1;
        tick();
        n_cmp++;
        if ({o_tx_valid, o_tx_byte, o_mem_cs, o_mem_addr, o_mem_bank, o_busy, o_state} !== '0) begin
            n_mis++;
            $display("FAIL reset_mid: valid=%b byte=%h cs=%h addr=%h bank=%b busy=%b state=%0d want all 0",
                     o_tx_valid, o_tx_byte, o_mem_cs, o_mem_addr, o_mem_bank, o_busy, o_state);
        end
        i_tx_ready = 1'b0;
        i_cs       = 1'b1;
        i_rst      = 1'b1;
        tick();
        test_status(8'h00, "reset_status");
    endtask

    task automatic test_id_backpressure();
        exp_q.delete();
        open_cs("id");
        send_byte(8'h9F);
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if (o_tx_valid !== 1'b1 || o_tx_byte !== 8'hA5) begin
                n_mis++;
                $display("FAIL id_hold cyc%0d: valid=%b byte=%h want 1/a5", i, o_tx_valid, o_tx_byte);
            end
            tick();
        end
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h14);
        exp_q.push_back(8'h08);
        exp_q.push_back(8'h00);
        recv(4, 0, "id");
        close_cs("id");
    endtask

    task automatic test_abort();
        int gap;
        open_cs("abort");
        send_byte(8'h03);
        send_byte(8'h00);
        send_byte(8'h10);
        gap = 0;
        while (o_tx_valid !== 1'b1 && gap < 20) begin
            tick();
            gap++;
        end
        i_cs       = 1'b1;
        i_tx_ready = 1'b1;
        tick();
        i_tx_ready = 1'b0;
        n_cmp++;
        if (o_state !== 3'd0 || o_tx_valid !== 1'b0 || o_mem_cs !== '0) begin
            n_mis++;
            $display("FAIL abort: state=%0d valid=%b cs=%h want 0/0/0", o_state, o_tx_valid, o_mem_cs);
        end
    endtask

    task automatic test_drain();
        open_cs("drain");
        send_byte(8'h42);
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if (o_state !== 3'd7 || o_tx_valid !== 1'b0 || o_mem_cs !== '0) begin
                n_mis++;
                $display("FAIL drain cyc%0d: state=%0d valid=%b cs=%h want 7/0/0",
                         i, o_state, o_tx_valid, o_mem_cs);
            end
            i_tx_ready = 1'b1;
            send_byte(8'h03);
        end
        i_tx_ready = 1'b0;
        close_cs("drain");
    endtask

    initial begin
        test_reset();
        do_read(16'h0005, 2, "read_basic");
        do_read(16'h01FF, 3, "read_cross");
        do_read(16'h27FF, 2, "read_wrap");
        do_read(16'h2800, 2, "read_oor");
        test_status(8'h01, "status_oor");
        test_id_backpressure();
        test_abort();
        do_read(16'h0010, 1, "read_after_abort");
        test_drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
